// File: rtl/seg_disp_sched.sv
// seg_disp_sched: time-shares a 4-digit 7-segment display between four status
// sources with round-robin arbitration, a fixed hold per grant and a
// multi-cycle binary-to-BCD (shift-add-3) conversion of the granted value.
module seg_disp_sched #(
    parameter int unsigned HOLD_CYCLES = 24_000_000
) (
    input  logic        clk_24m,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [13:0] bin0,
    input  logic [13:0] bin1,
    input  logic [13:0] bin2,
    input  logic [13:0] bin3,
    output logic [3:0]  grant,
    output logic [15:0] disp_bcd,
    output logic [1:0]  disp_src,
    output logic        disp_valid,
    output logic        ovf
);
    localparam int unsigned N_SRC  = 4;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned N_DIG  = BCD_W / 4;
    localparam int unsigned SH_W   = BIN_W + BCD_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [BIN_W-1:0]  MAX_DEC   = BIN_W'(9999);
    localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(BIN_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARB, ST_LATCH, ST_CONV, ST_LOAD, ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   last_src_q, last_src_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               ovf_next_q, ovf_next_d;
    logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
    logic [SRC_W-1:0]   disp_src_q, disp_src_d;
    logic               disp_valid_q, disp_valid_d;
    logic               ovf_q, ovf_d;

    logic [BIN_W-1:0]   bin_sel;
    logic               win_found;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   cand;
    logic [SH_W-1:0]    sh_adj;
    logic [SH_W-1:0]    sh_nxt;

    // Value of the source that currently owns the display
    always_comb begin
        bin_sel = bin0;
        case (last_src_q)
            2'd0:    bin_sel = bin0;
            2'd1:    bin_sel = bin1;
            2'd2:    bin_sel = bin2;
            default: bin_sel = bin3;
        endcase
    end

    // Round-robin search starting just after the last granted source
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_src_q;
        cand      = '0;
        for (int k = 1; k <= int'(N_SRC); k++) begin
            cand = last_src_q + SRC_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // One shift-add-3 step: correct nibbles >= 5, then shift left
    always_comb begin
        sh_adj = shreg_q;
        for (int n = 0; n < int'(N_DIG); n++) begin
            if (shreg_q[BIN_W + 4*n +: 4] >= 4'd5) begin
                sh_adj[BIN_W + 4*n +: 4] = shreg_q[BIN_W + 4*n +: 4] + 4'd3;
            end
        end
        sh_nxt = {sh_adj[SH_W-2:0], 1'b0};
    end

    // Next-state and register-input logic
    always_comb begin
        state_d      = state_q;
        last_src_d   = last_src_q;
        grant_d      = grant_q;
        shreg_d      = shreg_q;
        conv_cnt_d   = conv_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        ovf_next_d   = ovf_next_q;
        disp_bcd_d   = disp_bcd_q;
        disp_src_d   = disp_src_q;
        disp_valid_d = 1'b0;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (win_found) begin
                    grant_d    = 4'b0001 << win_idx;
                    last_src_d = win_idx;
                    state_d    = ST_LATCH;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                ovf_next_d = (bin_sel > MAX_DEC);
                shreg_d    = {BCD_W'(0), (bin_sel > MAX_DEC) ? MAX_DEC : bin_sel};
                conv_cnt_d = '0;
                state_d    = ST_CONV;
            end
            ST_CONV: begin
                shreg_d    = sh_nxt;
                conv_cnt_d = conv_cnt_q + CNT_W'(1);
                // Final step lands the result so it is visible during LOAD
                if (conv_cnt_q == CONV_LAST) begin
                    disp_bcd_d   = sh_nxt[SH_W-1 -: BCD_W];
                    disp_src_d   = last_src_q;
                    ovf_d        = ovf_next_q;
                    disp_valid_d = 1'b1;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hold_cnt_d = '0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (|req) begin
                        state_d = ST_ARB;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_src_q   <= SRC_W'(3);
            grant_q      <= '0;
            shreg_q      <= '0;
            conv_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            ovf_next_q   <= 1'b0;
            disp_bcd_q   <= '0;
            disp_src_q   <= '0;
            disp_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_src_q   <= last_src_d;
            grant_q      <= grant_d;
            shreg_q      <= shreg_d;
            conv_cnt_q   <= conv_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            ovf_next_q   <= ovf_next_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_src_q   <= disp_src_d;
            disp_valid_q <= disp_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign grant      = grant_q;
    assign disp_bcd   = disp_bcd_q;
    assign disp_src   = disp_src_q;
    assign disp_valid = disp_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Scoreboard bench for seg_disp_sched with a short hold period.
module tb_seg_disp_sched;
    localparam int unsigned HOLD = 10;

    logic        clk_24m;
    logic        rst_n;
    logic [3:0]  req;
    logic [13:0] bin0, bin1, bin2, bin3;
    logic [3:0]  grant;
    logic [15:0] disp_bcd;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        ovf;

    typedef struct packed {
        logic [15:0] bcd;
        logic [1:0]  src;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;
    int   cyc;

    seg_disp_sched #(.HOLD_CYCLES(HOLD)) dut (
        .clk_24m    (clk_24m),
        .rst_n      (rst_n),
        .req        (req),
        .bin0       (bin0),
        .bin1       (bin1),
        .bin2       (bin2),
        .bin3       (bin3),
        .grant      (grant),
        .disp_bcd   (disp_bcd),
        .disp_src   (disp_src),
        .disp_valid (disp_valid),
        .ovf        (ovf)
    );

    // Clock and free-running cycle counter
    initial clk_24m = 1'b0;
    always #5 clk_24m = ~clk_24m;
    initial cyc = 0;
    always @(posedge clk_24m) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_24m);
        #1;
    endtask

    task automatic push(input logic [15:0] b, input logic [1:0] s, input logic o);
        exp_t e;
        e.bcd = b;
        e.src = s;
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    // Advance until disp_valid is seen, bounded
    task automatic wait_valid(output int at);
        int n;
        n  = 0;
        at = -1;
        while (!disp_valid && n < 60) begin
            tick(1);
            n++;
        end
        if (disp_valid) begin
            at = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got none expected disp_valid within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    // Monitor: compare every displayed update against the scoreboard
    always @(negedge clk_24m) begin
        if (rst_n && disp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got bcd 0x%0h src %0d expected no update", disp_bcd, disp_src);
            end else begin
                mon_e = sb_q.pop_front();
                chk("disp_bcd", 32'(disp_bcd), 32'(mon_e.bcd));
                chk("disp_src", 32'(disp_src), 32'(mon_e.src));
                chk("ovf",      32'(ovf),      32'(mon_e.ovf));
            end
        end
    end

    // Stimulus
    initial begin
        int t0, t, prev;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        bin0   = '0;
        bin1   = '0;
        bin2   = '0;
        bin3   = '0;
        tick(3);
        chk("rst_grant",    32'(grant),      32'h0);
        chk("rst_disp_bcd", 32'(disp_bcd),   32'h0);
        chk("rst_disp_src", 32'(disp_src),   32'h0);
        chk("rst_valid",    32'(disp_valid), 32'h0);
        chk("rst_ovf",      32'(ovf),        32'h0);
        rst_n = 1'b1;
        tick(2);

        // Single request, first grant goes to source 0
        bin0 = 14'd1234;
        push(16'h1234, 2'd0, 1'b0);
        req = 4'b0001;
        t0  = cyc;
        tick(1);
        chk("t1_grant_arb", 32'(grant), 32'h0);
        tick(1);
        chk("t1_grant", 32'(grant), 32'h1);
        wait_valid(t);
        chk("t1_latency", 32'(t - t0), 32'd17);
        req = 4'b0000;
        tick(HOLD - 1);
        chk("t1_hold_grant", 32'(grant), 32'h1);
        tick(1);
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_retained", 32'(disp_bcd), 32'h1234);

        // Source 3 alone, small value
        bin3 = 14'd10;
        push(16'h0010, 2'd3, 1'b0);
        req = 4'b1000;
        t0  = cyc;
        tick(2);
        chk("t6_grant", 32'(grant), 32'h8);
        wait_valid(t);
        chk("t6_latency", 32'(t - t0), 32'd17);
        req = 4'b0000;
        tick(HOLD);
        chk("t6_idle_grant", 32'(grant), 32'h0);

        // All four requesting: round robin, saturation, sample-once
        bin0 = 14'd0;
        bin1 = 14'd42;
        bin2 = 14'd12000;
        bin3 = 14'd9999;
        push(16'h0000, 2'd0, 1'b0);
        push(16'h0042, 2'd1, 1'b0);
        push(16'h9999, 2'd2, 1'b1);
        push(16'h9999, 2'd3, 1'b0);
        push(16'h0005, 2'd0, 1'b0);
        push(16'h7777, 2'd1, 1'b0);
        push(16'h0000, 2'd2, 1'b0);
        req  = 4'b1111;
        t0   = cyc;
        prev = 0;
        for (int r = 0; r < 7; r++) begin
            wait_valid(t);
            if (r == 0) chk("rr_latency", 32'(t - t0), 32'd17);
            else        chk("rr_spacing", 32'(t - prev), 32'(HOLD + 16));
            prev = t;
            if (r < 6) begin
                tick(13);
                if (r == 0) begin
                    bin1 = 14'd7777;
                    bin0 = 14'd5;
                end
                if (r == 1) bin2 = 14'd0;
            end
        end
        req = 4'b0000;
        tick(HOLD - 1);
        chk("rr_hold_grant", 32'(grant), 32'h4);
        tick(1);
        chk("rr_idle_grant", 32'(grant), 32'h0);
        chk("rr_retained", 32'(disp_bcd), 32'h0000);

        // Single requester held: fresh sample on each re-grant
        push(16'h7777, 2'd1, 1'b0);
        push(16'h0123, 2'd1, 1'b0);
        req = 4'b0010;
        wait_valid(t);
        prev = t;
        bin1 = 14'd123;
        tick(1);
        wait_valid(t);
        chk("single_spacing", 32'(t - prev), 32'(HOLD + 16));
        tick(HOLD + 5);
        chk("pre_rst_grant", 32'(grant), 32'h2);

        // Asynchronous reset in the middle of a conversion
        rst_n = 1'b0;
        #1;
        chk("arst_grant",    32'(grant),      32'h0);
        chk("arst_disp_bcd", 32'(disp_bcd),   32'h0);
        chk("arst_valid",    32'(disp_valid), 32'h0);
        req = 4'b1010;
        tick(2);
        rst_n = 1'b1;
        push(16'h0123, 2'd1, 1'b0);
        t0 = cyc;
        tick(2);
        chk("post_rst_grant", 32'(grant), 32'h2);
        wait_valid(t);
        chk("post_rst_latency", 32'(t - t0), 32'd17);
        req = 4'b0000;
        tick(HOLD + 2);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
